mulwb: RTL and testbench
========================

# mulwb

The `mulwb` block is the multiply writeback stage of the MDU. It sits directly after the multiplier's Memory-stage partial-product sum and consumes the double-width product in M. It selects the architectural result (low word, high word, or sign-extended 32-bit word), registers it into the Writeback stage under pipeline stall/flush control, and produces a retired-multiply event and counter for the hardware performance monitor.

## Interface
Parameters:
- `XLEN`, 64, datapath width: 32 or 64.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `StallW`  input  1  Writeback stall; holds all W-stage state.
- `FlushW`  input  1  Writeback flush; synchronous clear of W-stage state.
- `ProdM`  input  2*XLEN  double-width product, valid in M.
- `Funct3M`  input  3  multiply type: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `W64M`  input  1  word-op (MULW); meaningful only when XLEN=64.
- `MulValidM`  input  1  the instruction in M is a multiply.
- `MulResultW`  output  XLEN  selected multiply result in W.
- `MulValidW`  output  1  `MulResultW` belongs to a valid multiply.
- `MulEventW`  output  1  one-cycle pulse when a multiply retires.
- `MulCountW`  output  32  count of retired multiplies.

## Operation
- Result select, combinational in M:
  - Funct3M=000, W64M=0: `ProdM[XLEN-1:0]`.
  - Funct3M=000, W64M=1, XLEN=64: `{{32{ProdM[31]}}, ProdM[31:0]}`.
  - Funct3M ∈ {001, 010, 011}: `ProdM[2*XLEN-1:XLEN]`. W64M is ignored.
  - Funct3M[2]=1 (a divide opcode) with MulValidM=1: the selected result is 0 and the valid qualifier is 0, so it is neither written nor counted.
  - When XLEN=32, W64M is ignored entirely.
- W register: {result, qualified valid}, where qualified valid = MulValidM & ~Funct3M[2].
  - Priority: reset > FlushW > StallW > load.
  - Reset or FlushW: `MulResultW`=0, `MulValidW`=0.
  - StallW=1 and FlushW=0: hold.
  - Otherwise: load the M-stage selection.
- Retire event:
  - `MulEventW` = `MulValidW` & ~`StallW` & ~`FlushW`. It is combinational from W-stage state and inputs.
  - A multiply held by N stall cycles produces exactly one pulse.
- Counter:
  - `MulCountW` increments by 1 in every cycle where `MulEventW`=1.
  - It wraps from 0xFFFF_FFFF to 0. No other clear except reset.
  - FlushW does not clear the counter.

## Timing
- Latency: ProdM/Funct3M/W64M/MulValidM sampled at the end of cycle M appear on `MulResultW`/`MulValidW` in cycle M+1, provided StallW=0 at that edge.
- `MulEventW` is asserted in the first W cycle with StallW=0. `MulCountW` reflects that event one cycle later.
- Reset values: `MulResultW`=0, `MulValidW`=0, `MulEventW`=0, `MulCountW`=0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. No event is generated for the instruction in flight.
- FlushW and StallW both asserted: flush wins. The W register clears at the edge, and `MulEventW`=0 in that cycle.
- Back-to-back multiplies with no stalls: one result per cycle and one pulse per cycle. The counter advances every cycle.
- Releasing a stall: the held result is visible for the whole stall. The next M instruction loads on the first edge with StallW=0.

## Test plan
- XLEN=32, ProdM=0xFFFF_FFFE_0000_0001, MulValidM=1, Funct3M=001 -> next cycle `MulResultW`=0xFFFF_FFFE, `MulValidW`=1, `MulEventW`=1. Repeat with Funct3M=000 -> `MulResultW`=0x0000_0001.
- XLEN=64, W64M=1, Funct3M=000, ProdM low 64 bits = 0x1234_5678_8000_0000 -> `MulResultW`=0xFFFF_FFFF_8000_0000. Repeat with W64M=1, Funct3M=011 -> high 64 bits returned, W64M ignored.
- Valid MUL loaded, then StallW=1 for 3 cycles -> `MulResultW` held, `MulEventW`=0 throughout. On release -> one pulse; `MulCountW` goes 0→1.
- StallW=1 and FlushW=1 in the same cycle with `MulValidW`=1 -> `MulEventW`=0, W register cleared, `MulCountW` unchanged.
- MulValidM=1 with Funct3M=100 -> `MulValidW`=0, `MulResultW`=0, no event.
- Counter preloaded to 0xFFFF_FFFF via 2^32-1 events (or force), then one more retire -> `MulCountW`=0. Async reset mid-stream -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/mulwb.sv
// Multiply writeback stage: picks the architectural word out of the M-stage product,
// registers it into W under stall/flush, and counts retired multiplies.
`timescale 1ns/1ps

module mulwb #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallW,
    input  logic              FlushW,
    input  logic [2*XLEN-1:0] ProdM,
    input  logic [2:0]        Funct3M,
    input  logic              W64M,
    input  logic              MulValidM,
    output logic [XLEN-1:0]   MulResultW,
    output logic              MulValidW,
    output logic              MulEventW,
    output logic [31:0]       MulCountW
);

    logic [XLEN-1:0] result_d, result_q;
    logic            valid_d, valid_q;
    logic [31:0]     count_d, count_q;
    logic [XLEN-1:0] lowSel;

    // MULW only exists on RV64; a 32-bit datapath always takes the plain low word.
    generate
        if (XLEN == 64) begin : g_rv64
            assign lowSel = W64M ? {{(XLEN-32){ProdM[31]}}, ProdM[31:0]} : ProdM[XLEN-1:0];
        end else begin : g_rv32
            assign lowSel = ProdM[XLEN-1:0];
        end
    endgenerate

    always_comb begin
        result_d = '0;
        valid_d  = MulValidM & ~Funct3M[2];
        if (!Funct3M[2]) begin
            if (Funct3M[1:0] == 2'b00) begin
                result_d = lowSel;
            end else begin
                result_d = ProdM[2*XLEN-1:XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (FlushW) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (!StallW) begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    // A stalled multiply only retires in the cycle its stall drops, so it pulses once.
    assign MulEventW = valid_q & ~StallW & ~FlushW;
    assign count_d   = count_q + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (MulEventW) begin
            count_q <= count_d;
        end
    end

    assign MulResultW = result_q;
    assign MulValidW  = valid_q;
    assign MulCountW  = count_q;

endmodule

// File: tb/tb_mulwb.sv
// Scoreboard bench for mulwb: one RV64 and one RV32 instance share control inputs;
// each retire event pops the hand-computed result expected for that instance.
`timescale 1ns/1ps

module tb_mulwb;

    logic         clk;
    logic         reset;
    logic         StallW;
    logic         FlushW;
    logic [127:0] ProdM64;
    logic [63:0]  ProdM32;
    logic [2:0]   Funct3M;
    logic         W64M;
    logic         MulValidM;

    logic [63:0]  MulResultW64;
    logic         MulValidW64, MulEventW64;
    logic [31:0]  MulCountW64;
    logic [31:0]  MulResultW32;
    logic         MulValidW32, MulEventW32;
    logic [31:0]  MulCountW32;

    logic [63:0]  q64[$];
    logic [31:0]  q32[$];
    logic [31:0]  cnt64, cnt32;
    logic [31:0]  savedCount;
    int           vectors, errors;

    mulwb #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .ProdM(ProdM64), .Funct3M(Funct3M), .W64M(W64M), .MulValidM(MulValidM),
        .MulResultW(MulResultW64), .MulValidW(MulValidW64),
        .MulEventW(MulEventW64), .MulCountW(MulCountW64)
    );

    mulwb #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .ProdM(ProdM32), .Funct3M(Funct3M), .W64M(W64M), .MulValidM(MulValidM),
        .MulResultW(MulResultW32), .MulValidW(MulValidW32),
        .MulEventW(MulEventW32), .MulCountW(MulCountW32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one M-stage instruction at the falling edge and queues what should retire.
    task automatic applyStimulus(input logic [2:0] f3, input logic w64,
                                 input logic [127:0] p64, input logic [63:0] p32,
                                 input logic [63:0] e64, input logic [31:0] e32);
        @(negedge clk);
        Funct3M   = f3;
        W64M      = w64;
        ProdM64   = p64;
        ProdM32   = p32;
        MulValidM = 1'b1;
        StallW    = 1'b0;
        FlushW    = 1'b0;
        if (!f3[2]) begin
            q64.push_back(e64);
            q32.push_back(e32);
        end
    endtask

    task automatic idle(input logic stall, input logic flush);
        @(negedge clk);
        MulValidM = 1'b0;
        Funct3M   = 3'b000;
        W64M      = 1'b0;
        ProdM64   = {4{32'hF0F0_5A5A}};
        ProdM32   = {2{32'h0F0F_A5A5}};
        StallW    = stall;
        FlushW    = flush;
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_res64"}, MulResultW64, 64'h0);
        checkOutput({tag, "_val64"}, {63'h0, MulValidW64}, 64'h0);
        checkOutput({tag, "_evt64"}, {63'h0, MulEventW64}, 64'h0);
        checkOutput({tag, "_res32"}, {32'h0, MulResultW32}, 64'h0);
        checkOutput({tag, "_val32"}, {63'h0, MulValidW32}, 64'h0);
        checkOutput({tag, "_evt32"}, {63'h0, MulEventW32}, 64'h0);
    endtask

    // Monitor: every retire pops the oldest expectation and checks the pre-increment count.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && MulEventW64) begin
                if (q64.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("[TB] FAIL evt64_unexpected: got result %h, expected no retire", MulResultW64);
                end else begin
                    checkOutput("res64", MulResultW64, q64.pop_front());
                    checkOutput("cnt64_at_evt", {32'h0, MulCountW64}, {32'h0, cnt64});
                    cnt64 = cnt64 + 32'd1;
                end
            end
            if (!reset && MulEventW32) begin
                if (q32.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("[TB] FAIL evt32_unexpected: got result %h, expected no retire", MulResultW32);
                end else begin
                    checkOutput("res32", {32'h0, MulResultW32}, {32'h0, q32.pop_front()});
                    checkOutput("cnt32_at_evt", {32'h0, MulCountW32}, {32'h0, cnt32});
                    cnt32 = cnt32 + 32'd1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors   = 0;
        errors    = 0;
        cnt64     = 32'h0;
        cnt32     = 32'h0;
        reset     = 1'b1;
        StallW    = 1'b0;
        FlushW    = 1'b0;
        MulValidM = 1'b0;
        Funct3M   = 3'b000;
        W64M      = 1'b0;
        ProdM64   = '0;
        ProdM32   = '0;

        repeat (2) @(negedge clk);
        #2;
        checkCleared("reset");
        checkOutput("reset_cnt64", {32'h0, MulCountW64}, 64'h0);
        checkOutput("reset_cnt32", {32'h0, MulCountW32}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back retires: MULH, MUL, MULW, MULHU with W64 set, MULHSU, MULW positive.
        applyStimulus(3'b001, 1'b0, 128'h0000_0000_0000_0003_FFFF_FFFF_FFFF_FFFD,
                      64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0003, 32'hFFFF_FFFE);
        applyStimulus(3'b000, 1'b0, 128'h0000_0000_0000_0003_FFFF_FFFF_FFFF_FFFD,
                      64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFFD, 32'h0000_0001);
        applyStimulus(3'b000, 1'b1, 128'hAAAA_AAAA_AAAA_AAAA_1234_5678_8000_0000,
                      64'h0000_0005_8000_0000, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000);
        applyStimulus(3'b011, 1'b1, 128'hDEAD_BEEF_0000_0001_1234_5678_8000_0000,
                      64'h1234_5678_9ABC_DEF0, 64'hDEAD_BEEF_0000_0001, 32'h1234_5678);
        applyStimulus(3'b010, 1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0001,
                      64'h7FFF_FFFF_0000_0000, 64'h8000_0000_0000_0000, 32'h7FFF_FFFF);
        applyStimulus(3'b000, 1'b1, 128'h0000_0000_0000_0000_FFFF_FFFF_7FFF_FFFF,
                      64'h0000_0001_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 32'h7FFF_FFFF);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        #2;
        checkOutput("b2b_cnt64", {32'h0, MulCountW64}, 64'd6);

        // Three stall cycles hold the result with no event; release gives one retire.
        applyStimulus(3'b000, 1'b0, 128'h0000_0000_0000_00AB, 64'h0000_0000_0000_00CD,
                      64'h0000_0000_0000_00AB, 32'h0000_00CD);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b0);
            #2;
            checkOutput("stall_hold64", MulResultW64, 64'h0000_0000_0000_00AB);
            checkOutput("stall_hold32", {32'h0, MulResultW32}, 64'h0000_0000_0000_00CD);
            checkOutput("stall_noevt", {62'h0, MulEventW64, MulEventW32}, 64'h0);
        end
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        #2;
        checkOutput("stall_cnt64", {32'h0, MulCountW64}, 64'd7);

        // Flush with stall: flush wins, nothing retires, counter untouched.
        applyStimulus(3'b000, 1'b0, 128'h55, 64'h66, 64'h55, 32'h66);
        idle(1'b1, 1'b1);
        #2;
        checkOutput("flush_noevt", {62'h0, MulEventW64, MulEventW32}, 64'h0);
        savedCount = cnt64;
        void'(q64.pop_back());
        void'(q32.pop_back());
        idle(1'b0, 1'b0);
        #2;
        checkCleared("flush");
        checkOutput("flush_cnt64", {32'h0, MulCountW64}, {32'h0, savedCount});

        // A divide opcode in M is neither written nor counted.
        applyStimulus(3'b100, 1'b0, 128'h1234, 64'h5678, 64'h0, 32'h0);
        idle(1'b0, 1'b0);
        #2;
        checkCleared("div");

        // Counter wrap on the 64-bit instance.
        idle(1'b0, 1'b0);
        force dut64.count_q = 32'hFFFF_FFFF;
        cnt64 = 32'hFFFF_FFFF;
        idle(1'b0, 1'b0);
        release dut64.count_q;
        #2;
        checkOutput("wrap_preload", {32'h0, MulCountW64}, 64'h0000_0000_FFFF_FFFF);
        applyStimulus(3'b000, 1'b0, 128'h77, 64'h88, 64'h77, 32'h88);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        #2;
        checkOutput("wrap_cnt64", {32'h0, MulCountW64}, 64'h0);
        checkOutput("wrap_cnt32", {32'h0, MulCountW32}, {32'h0, cnt32});

        // Asynchronous reset while a stalled multiply sits in W.
        applyStimulus(3'b000, 1'b0, 128'h99, 64'hAA, 64'h99, 32'hAA);
        idle(1'b1, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checkCleared("async_rst");
        checkOutput("async_rst_cnt64", {32'h0, MulCountW64}, 64'h0);
        checkOutput("async_rst_cnt32", {32'h0, MulCountW32}, 64'h0);
        void'(q64.pop_back());
        void'(q32.pop_back());
        cnt64 = 32'h0;
        cnt32 = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        idle(1'b0, 1'b0);
        #2;
        checkCleared("post_rst");

        repeat (2) @(negedge clk);
        checkOutput("sb64_empty", 64'(q64.size()), 64'h0);
        checkOutput("sb32_empty", 64'(q32.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
